// File: rtl/dma_job_scheduler_pkg.sv
// dma_sched_pkg: register map, bit indices, engine ids, FSM states and job layout
package dma_sched_pkg;
  localparam int N_ENG = 3;
  localparam int LEN_W = 16;
  localparam int IRQ_W = N_ENG + 2;
  localparam logic [7:0] REG_CTRL = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h04;
  localparam logic [7:0] REG_SRC = 8'h08;
  localparam logic [7:0] REG_DST = 8'h0C;
  localparam logic [7:0] REG_JOB = 8'h10;
  localparam logic [7:0] REG_IRQ = 8'h18;
  localparam int CTRL_EN = 0;
  localparam int CTRL_SERIAL = 1;
  localparam int CTRL_FLUSH = 2;
  localparam int CTRL_IRQ_EN = 8;
  localparam logic [31:0] CTRL_MASK = 32'h0000_1F03;
  localparam int ST_FULL = 4;
  localparam int ST_EMPTY = 5;
  localparam int ST_INFL = 8;
  localparam int ST_BUSY = 12;
  localparam int IRQ_OVF = 3;
  localparam int IRQ_BAD = 4;
  localparam logic [1:0] ENG_FIR = 2'd0;
  localparam logic [1:0] ENG_QS = 2'd1;
  localparam logic [1:0] ENG_MM = 2'd2;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dst;
    logic [LEN_W-1:0] len;
    logic [1:0] eng;
  } job_t;
  localparam int JOB_W = $bits(job_t);
  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction
endpackage

// File: rtl/dma_job_scheduler_if.sv
// dma_job_scheduler_if: Wishbone slave bus bundle
interface dma_job_scheduler_if;
  logic wbs_stb_i;
  logic wbs_cyc_i;
  logic wbs_we_i;
  logic [3:0] wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic wbs_ack_o;
  logic [31:0] wbs_dat_o;
  modport slave(input wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i, output wbs_ack_o, wbs_dat_o);
  modport master(output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i, input wbs_ack_o, wbs_dat_o);
endinterface

// File: rtl/dma_job_scheduler_fifo.sv
// dma_job_fifo: synchronous job FIFO with flush and occupancy count
module dma_job_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty,
  output logic [AW:0] count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign count = wp - rp;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = wp == rp;
  assign dout = mem[rp[AW-1:0]];
  // storage array, written only when there is room
  always_ff @(posedge clk)
    if (push && !full) mem[wp[AW-1:0]] <= din;
  // pointers; flush takes priority over push and pop
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
endmodule

// File: rtl/dma_job_scheduler.sv
// dma_job_scheduler: Wishbone job queue dispatching descriptors to the DMA engines
module dma_job_scheduler
  import dma_sched_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_8000,
  parameter int QDEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  dma_job_scheduler_if.slave wb,
  output logic [N_ENG-1:0] eng_start_o,
  output logic [32*N_ENG-1:0] eng_src_o,
  output logic [32*N_ENG-1:0] eng_dst_o,
  output logic [LEN_W*N_ENG-1:0] eng_len_o,
  input  logic [N_ENG-1:0] eng_busy_i,
  input  logic [N_ENG-1:0] eng_done_i,
  output logic irq_o
);
  localparam int CW = $clog2(QDEPTH) + 1;
  state_t state, nstate;
  logic [31:0] ctrl_q, src_q, dst_q, wdat, m, rdata, status;
  logic [IRQ_W-1:0] irq_q, w1c;
  logic [N_ENG-1:0] infl, hd_oh;
  logic [1:0] iss_eng;
  logic [7:0] off;
  logic hit, wr, job_wr, bad, ovf, push, pop, flush, full, empty, go;
  logic [CW-1:0] count;
  logic [JOB_W-1:0] dout;
  job_t hd, nj;
  dma_job_fifo #(.W(JOB_W), .DEPTH(QDEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .flush(flush),
    .din(nj), .dout(dout), .full(full), .empty(empty), .count(count)
  );
  // bus decode, push qualification, dispatch decision and read mux
  always_comb begin
    off = wb.wbs_adr_i[7:0];
    hit = wb.wbs_stb_i && wb.wbs_cyc_i && wb.wbs_adr_i[31:8] == BASE_ADDR[31:8] && !wb.wbs_ack_o;
    wr = hit && wb.wbs_we_i;
    m = byte_mask(wb.wbs_sel_i);
    wdat = wb.wbs_dat_i & m;
    nj = '{src: src_q, dst: dst_q, len: wdat[LEN_W-1:0], eng: wdat[17:16]};
    job_wr = wr && off == REG_JOB;
    bad = job_wr && (nj.eng >= 2'(N_ENG) || nj.len == '0);
    ovf = job_wr && !bad && full;
    push = job_wr && !bad && !full;
    flush = wr && off == REG_CTRL && wdat[CTRL_FLUSH];
    w1c = (wr && off == REG_IRQ) ? wdat[IRQ_W-1:0] : '0;
    hd = job_t'(dout);
    hd_oh = N_ENG'(1) << hd.eng;
    go = state == S_IDLE && ctrl_q[CTRL_EN] && !empty && !(|(hd_oh & (eng_busy_i | infl)));
    pop = state == S_ISSUE;
    nstate = state == S_IDLE ? (go ? S_ISSUE : S_IDLE) :
             state == S_ISSUE ? (ctrl_q[CTRL_SERIAL] ? S_WAIT : S_IDLE) :
             (eng_done_i[iss_eng] ? S_IDLE : S_WAIT);
    eng_start_o = state == S_ISSUE ? N_ENG'(1) << iss_eng : '0;
    irq_o = |(irq_q & ctrl_q[CTRL_IRQ_EN +: IRQ_W]);
    status = '0;
    status[CW-1:0] = count;
    status[ST_FULL] = full;
    status[ST_EMPTY] = empty;
    status[ST_INFL +: N_ENG] = infl;
    status[ST_BUSY] = state != S_IDLE;
    rdata = off == REG_CTRL ? ctrl_q :
            off == REG_STATUS ? status :
            off == REG_SRC ? src_q :
            off == REG_DST ? dst_q :
            off == REG_IRQ ? 32'(irq_q) : '0;
  end
  // registers, ack/read data, FSM state and per-engine descriptor outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wb.wbs_ack_o <= 1'b0;
      wb.wbs_dat_o <= '0;
      ctrl_q <= '0;
      src_q <= '0;
      dst_q <= '0;
      irq_q <= '0;
      infl <= '0;
      iss_eng <= '0;
      state <= S_IDLE;
      eng_src_o <= '0;
      eng_dst_o <= '0;
      eng_len_o <= '0;
    end else begin
      wb.wbs_ack_o <= hit;
      wb.wbs_dat_o <= (hit && !wb.wbs_we_i) ? rdata : '0;
      if (wr && off == REG_CTRL) ctrl_q <= ((ctrl_q & ~m) | wdat) & CTRL_MASK;
      if (wr && off == REG_SRC) src_q <= (src_q & ~m) | wdat;
      if (wr && off == REG_DST) dst_q <= (dst_q & ~m) | wdat;
      irq_q <= (irq_q & ~w1c) | {bad, ovf, eng_done_i};
      infl <= (infl & ~eng_done_i) | (go ? hd_oh : '0);
      state <= nstate;
      if (go) iss_eng <= hd.eng;
      for (int e = 0; e < N_ENG; e++)
        if (go && hd.eng == 2'(e)) begin
          eng_src_o[32*e +: 32] <= hd.src;
          eng_dst_o[32*e +: 32] <= hd.dst;
          eng_len_o[LEN_W*e +: LEN_W] <= hd.len;
        end
    end
endmodule

// File: doc/dma_job_scheduler.md
# dma_job_scheduler

Wishbone-slave job queue and dispatcher for the three user-area DMA engines (FIR, QS, MM). Firmware pushes descriptors (engine, source, destination, length) into a 4-deep FIFO. The block issues each head-of-queue job to its engine with a start pulse, tracks completion, and raises a maskable interrupt. It sits in the 0x30xx_xxxx decode space beside the engines and replaces per-engine polling by the CPU.

## Interface
- BASE_ADDR, 32'h3000_8000 — register window base; decode on adr_i[31:8]==BASE_ADDR[31:8]
- QDEPTH, 4 — job FIFO depth (power of two)
- N_ENG, 3 — number of engines; ids 0=FIR, 1=QS, 2=MM
- LEN_W, 16 — transfer length width, in words
- clk  in  1  single clock (wb_clk_i domain)
- rst_n  in  1  asynchronous, active-low reset
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone slave strobe, cycle, write-enable
- wbs_sel_i  in  4  byte selects; writes honour sel per byte
- wbs_adr_i, wbs_dat_i  in  32 each  address, write data
- wbs_ack_o  out  1  single-cycle acknowledge
- wbs_dat_o  out  32  read data; 0 when not acking
- eng_start_o  out  N_ENG  one-cycle start pulse per engine
- eng_src_o, eng_dst_o  out  32*N_ENG  per-engine source/destination address
- eng_len_o  out  LEN_W*N_ENG  per-engine length
- eng_busy_i  in  N_ENG  engine running
- eng_done_i  in  N_ENG  one-cycle completion pulse
- irq_o  out  1  level interrupt

## Operation
- Registers, word offsets:
  - 0x00 CTRL rw: bit0 EN; bit1 SERIAL; bit2 FLUSH (self-clearing write-1); bits[12:8] IRQ_EN.
  - 0x04 STATUS ro: [2:0] count, bit4 full, bit5 empty, [10:8] inflight, bit12 fsm!=IDLE.
  - 0x08 SRC rw and 0x0C DST rw: staging registers.
  - 0x10 JOB wo: [15:0] len, [17:16] eng. A write pushes {SRC, DST, len, eng}.
  - 0x18 IRQ_STAT: rw1c. Bits[2:0] done per engine; bit3 overflow (push while full); bit4 bad_eng (eng>=N_ENG or len==0).
- Bad or overflowing pushes are dropped and set the matching IRQ_STAT bit.
- irq_o = |(IRQ_STAT & IRQ_EN).
- Dispatch FSM:
  - IDLE: go to ISSUE when EN=1, the queue is not empty, the head engine has eng_busy_i=0, and the head engine's inflight bit is 0.
  - ISSUE: one cycle. Load eng_*_o[head], pulse eng_start_o[head], set inflight[head], pop. Go to WAIT if SERIAL=1, else IDLE.
  - WAIT: hold until eng_done_i for the issued engine, then go to IDLE.
- Strict FIFO order. The head blocks later jobs (no reordering), but in parallel mode different engines can run concurrently.
- eng_done_i[e] clears inflight[e] and sets IRQ_STAT[e].
- Clearing EN stops new issues only. Jobs already running complete normally.

## Timing
- Reset: all outputs 0, queue empty, CTRL=0, IRQ_STAT=0, inflight=0, FSM=IDLE.
- Wishbone:
  - ack_o rises the cycle after stb&cyc&decode with ack_o=0, lasts one cycle, then deasserts. Minimum 2 cycles per access; back-to-back accesses are allowed.
  - Register writes and FIFO pushes take effect on the edge where ack_o rises.
- Issue latency:
  - Job pushed at edge T, eligible engine: FSM enters ISSUE at edge T+1 and eng_start_o is high during cycle T+1→T+2. Count decrements at T+2.
  - eng_*_o[e] hold their values until the next start to engine e.
- Simultaneous events:
  - Push while full with a pop on the same edge: the push is dropped and overflow is set (full is evaluated pre-pop).
  - FLUSH with a push on the same edge: FLUSH wins and the push is silently dropped. FLUSH never cancels an ISSUE already in progress.
  - eng_done_i and a w1c of the same bit on the same edge: the set wins.
  - eng_done_i for an engine with no inflight job: IRQ_STAT is still set and inflight stays 0.
- Count wraps correctly at QDEPTH and uses log2(QDEPTH)+1-bit pointers.
- Reset mid-job: the queue is lost and start is deasserted asynchronously. The engines share rst_n.

## Structure
- Package dma_sched_pkg holds:
  - register offsets and CTRL/STATUS/IRQ_STAT bit indices
  - engine id constants
  - FSM state encoding
  - job word layout (32+32+LEN_W+2 bits)
- Sub-module dma_job_fifo: synchronous FIFO, QDEPTH×job width, with push, pop, flush, full, empty and count outputs. Async active-low reset.

## Test plan
- Write SRC=0x3800_0000, DST=0x3800_0400, JOB={eng=0,len=64} with EN=1 → eng_start_o=3'b001 for exactly one cycle, eng_src_o[0]=0x3800_0000, eng_len_o[0]=64. A done pulse sets IRQ_STAT=0x1, and irq_o=1 when IRQ_EN[0]=1.
- Parallel mode, jobs for eng 0, 1, 2 pushed back-to-back, all engines idle → three start pulses on successive ISSUE cycles, inflight=3'b111, queue empty.
- SERIAL=1, jobs for eng 0 then eng 1 → eng 1 starts only after eng_done_i[0]. STATUS fsm bit stays 1 during WAIT.
- Push 5 jobs to engine 2 while it is busy → count=4, full=1, IRQ_STAT bit3=1. After w1c of 0x8, IRQ_STAT=0.
- JOB write with eng=3 or len=0 → nothing queued, IRQ_STAT bit4=1. FLUSH with 3 queued → count=0 the next cycle and no start pulses.
- rst_n low during WAIT with 2 jobs queued → all outputs 0 immediately. STATUS reads empty=1 after release.
